alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequencer and arbiter that shares one alu instance between two issue requesters. It accepts one operation at a time using a round-robin grant and drives the ALU operand and code inputs. It waits for the ALU ready flag with a watchdog, chains two ALU passes for 128-bit wide operations, and returns the result through a back-pressured response port. It sits between the issue stage and the alu.

Parameters:
LEN_DATA, 64, operand/result width
LEN_TYPE_ALU, 6, ALU opcode width
LEN_TAG, 4, requester tag width
TIMEOUT, 15, max cycles waiting for alu_rdy per pass (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
reqN_valid  in  1  request valid (N=0,1; one port set per requester)
reqN_ready  out  1  request accepted when valid&ready
reqN_code  in  LEN_TYPE_ALU  ALU opcode
reqN_a, reqN_b  in  LEN_DATA  low operands
reqN_ah, reqN_bh  in  LEN_DATA  high operands (wide only)
reqN_imm  in  LEN_DATA  immediate
reqN_cin  in  1  carry in
reqN_wide  in  1  128-bit two-pass operation
reqN_tag  in  LEN_TAG  transaction tag
alu_en  out  1  one-cycle issue strobe
alu_code  out  LEN_TYPE_ALU  opcode to ALU
alu_a, alu_b, alu_imm  out  LEN_DATA  operands to ALU
alu_cin  out  1  carry to ALU
alu_result  in  LEN_DATA  ALU result
alu_cout  in  1  ALU carry out
alu_rdy  in  1  ALU result valid
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester index
rsp_tag  out  LEN_TAG  echoed tag
rsp_result  out  LEN_DATA  low result
rsp_ex_result  out  LEN_DATA  high result (wide), else 0
rsp_cout  out  1  final carry
rsp_err  out  1  watchdog expired

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer favours req0; in-flight op abandoned, no response produced.
- States: IDLE, ISSUE_L, WAIT_L, ISSUE_H, WAIT_H, RESP.
- IDLE: reqN_ready = 1 only in IDLE. If one requester is valid, it is granted. If both are valid, the pointer side is granted and the pointer then flips to the other side. Operands, tag and id are latched on the accept cycle. Next state is ISSUE_L.
- ISSUE_L: alu_en = 1 for exactly one cycle, with a/b/imm/cin/code. Operands are held stable on alu_* until the pass ends. Next state is WAIT_L, with the watchdog counter cleared.
- WAIT_L: on alu_rdy, capture alu_result/alu_cout. Wide ops go to ISSUE_H; others go to RESP. Each cycle without rdy increments the counter. At count = TIMEOUT, go to RESP with rsp_err = 1, result 0, cout 0.
- ISSUE_H: drive ah/bh, alu_cin = captured low cout, same code, for one cycle. Next state is WAIT_H.
- WAIT_H: rdy captures the high result into rsp_ex_result and cout into rsp_cout. Timeout handling is identical to WAIT_L; low and high results are both zeroed.
- Wide ops must carry a carry-using code. The controller does not check this.
- RESP: rsp_valid is held with stable payload until rsp_ready. The transfer cycle returns to IDLE, so a new accept is possible the following cycle.
- Minimum latency (ALU rdy one cycle after alu_en): accept at cycle N, alu_en at N+1, rdy at N+2, rsp_valid at N+3. Wide: rsp_valid at N+5.
- alu_rdy outside WAIT_L/WAIT_H is ignored. This includes a late rdy after timeout, and rdy in the same cycle as alu_en.
- rdy on the same cycle the count reaches TIMEOUT counts as success.

Test Plan:
1. Reset, then req0 valid with code ADD64, a=5, b=7 → alu_en pulse at N+1; ALU rdy at N+2 with 12 → rsp_valid at N+3, result=12, id=0, tag echoed, err=0.
2. req0 and req1 both valid for 3 consecutive operations → grant order 0,1,0; reqN_ready is never asserted for both in the same cycle.
3. Wide op with a=FFFF_FFFF_FFFF_FFFF, b=1, ah=0, bh=0 and an ADC-class code → second alu_en carries alu_cin=1; response result=0, ex_result=1, cout=0.
4. ALU never asserts rdy → rsp_valid at accept+2+TIMEOUT with err=1 and result 0; a later stray alu_rdy is ignored.
5. rsp_ready held low for 10 cycles → payload stable and reqN_ready=0 throughout; release → next accept one cycle after transfer.
6. rst asserted during WAIT_H → next cycle all outputs are 0 and state is IDLE; no response for the aborted tag.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Two-requester issue controller that time-shares one ALU: round-robin accept,
// one or two ALU passes (128-bit ops chain the carry), watchdog, held response.
module alu_issue_ctrl #(
    parameter int LEN_DATA     = 64,
    parameter int LEN_TYPE_ALU = 6,
    parameter int LEN_TAG      = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [LEN_TYPE_ALU-1:0] req0_code,
    input  logic [LEN_DATA-1:0]     req0_a,
    input  logic [LEN_DATA-1:0]     req0_b,
    input  logic [LEN_DATA-1:0]     req0_ah,
    input  logic [LEN_DATA-1:0]     req0_bh,
    input  logic [LEN_DATA-1:0]     req0_imm,
    input  logic                    req0_cin,
    input  logic                    req0_wide,
    input  logic [LEN_TAG-1:0]      req0_tag,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [LEN_TYPE_ALU-1:0] req1_code,
    input  logic [LEN_DATA-1:0]     req1_a,
    input  logic [LEN_DATA-1:0]     req1_b,
    input  logic [LEN_DATA-1:0]     req1_ah,
    input  logic [LEN_DATA-1:0]     req1_bh,
    input  logic [LEN_DATA-1:0]     req1_imm,
    input  logic                    req1_cin,
    input  logic                    req1_wide,
    input  logic [LEN_TAG-1:0]      req1_tag,
    output logic                    alu_en,
    output logic [LEN_TYPE_ALU-1:0] alu_code,
    output logic [LEN_DATA-1:0]     alu_a,
    output logic [LEN_DATA-1:0]     alu_b,
    output logic [LEN_DATA-1:0]     alu_imm,
    output logic                    alu_cin,
    input  logic [LEN_DATA-1:0]     alu_result,
    input  logic                    alu_cout,
    input  logic                    alu_rdy,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [LEN_TAG-1:0]      rsp_tag,
    output logic [LEN_DATA-1:0]     rsp_result,
    output logic [LEN_DATA-1:0]     rsp_ex_result,
    output logic                    rsp_cout,
    output logic                    rsp_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE_L, WAIT_L, ISSUE_H, WAIT_H, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d, id_q, id_d, cin_q, cin_d, wide_q, wide_d;
    logic                    cout_q, cout_d, err_q, err_d;
    logic [LEN_TAG-1:0]      tag_q, tag_d;
    logic [LEN_TYPE_ALU-1:0] code_q, code_d;
    logic [LEN_DATA-1:0]     a_q, a_d, b_q, b_d, ah_q, ah_d, bh_q, bh_d, imm_q, imm_d;
    logic [LEN_DATA-1:0]     res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    grant0, grant1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cin_d    = cin_q;
        wide_d   = wide_q;
        cout_d   = cout_q;
        err_d    = err_q;
        tag_d    = tag_q;
        code_d   = code_q;
        a_d      = a_q;
        b_d      = b_q;
        ah_d     = ah_q;
        bh_d     = bh_q;
        imm_d    = imm_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        cnt_d    = cnt_q;

        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        alu_en        = 1'b0;
        alu_code      = '0;
        alu_a         = '0;
        alu_b         = '0;
        alu_imm       = '0;
        alu_cin       = 1'b0;
        rsp_valid     = 1'b0;
        rsp_id        = 1'b0;
        rsp_tag       = '0;
        rsp_result    = '0;
        rsp_ex_result = '0;
        rsp_cout      = 1'b0;
        rsp_err       = 1'b0;

        // The pointer only matters, and only moves, when both sides contend.
        grant0 = req0_valid && (!req1_valid || !ptr_q);
        grant1 = req1_valid && (!req0_valid || ptr_q);

        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    id_d     = grant1;
                    ptr_d    = (req0_valid && req1_valid) ? ~ptr_q : ptr_q;
                    code_d   = grant1 ? req1_code : req0_code;
                    a_d      = grant1 ? req1_a    : req0_a;
                    b_d      = grant1 ? req1_b    : req0_b;
                    ah_d     = grant1 ? req1_ah   : req0_ah;
                    bh_d     = grant1 ? req1_bh   : req0_bh;
                    imm_d    = grant1 ? req1_imm  : req0_imm;
                    cin_d    = grant1 ? req1_cin  : req0_cin;
                    wide_d   = grant1 ? req1_wide : req0_wide;
                    tag_d    = grant1 ? req1_tag  : req0_tag;
                    res_lo_d = '0;
                    res_hi_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ISSUE_L;
                end
            end
            ISSUE_L, ISSUE_H: begin
                alu_en  = 1'b1;
                cnt_d   = '0;
                state_d = (state_q == ISSUE_L) ? WAIT_L : WAIT_H;
            end
            WAIT_L, WAIT_H: begin
                if (alu_rdy) begin
                    cout_d = alu_cout;
                    if (state_q == WAIT_L) begin
                        res_lo_d = alu_result;
                        state_d  = wide_q ? ISSUE_H : RESP;
                    end else begin
                        res_hi_d = alu_result;
                        state_d  = RESP;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    res_lo_d = '0;
                    res_hi_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid     = 1'b1;
                rsp_id        = id_q;
                rsp_tag       = tag_q;
                rsp_result    = res_lo_q;
                rsp_ex_result = res_hi_q;
                rsp_cout      = cout_q;
                rsp_err       = err_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Operands stay on the ALU bus for the whole pass; the high pass takes the low carry.
        if (state_q == ISSUE_L || state_q == WAIT_L) begin
            alu_code = code_q;
            alu_a    = a_q;
            alu_b    = b_q;
            alu_imm  = imm_q;
            alu_cin  = cin_q;
        end else if (state_q == ISSUE_H || state_q == WAIT_H) begin
            alu_code = code_q;
            alu_a    = ah_q;
            alu_b    = bh_q;
            alu_imm  = imm_q;
            alu_cin  = cout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            cin_q    <= 1'b0;
            wide_q   <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= '0;
            code_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ah_q     <= '0;
            bh_q     <= '0;
            imm_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cin_q    <= cin_d;
            wide_q   <= wide_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
            code_q   <= code_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ah_q     <= ah_d;
            bh_q     <= bh_d;
            imm_q    <= imm_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
